// File: rtl/dmx8_32bits_regs_pkg.sv
// Purpose: shared sizes and helpers for the 8-entry holding-register bank and its read mux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmx8_32bits_regs_pkg;

  // Bank geometry, shared with the 8:1 read-mux side of the operand path.
  localparam int NREG   = 8;
  localparam int REG_AW = 3;
  localparam int WORD_W = 32;

  // Where the write destination comes from on a given cycle.
  typedef enum logic {
    SRC_ADDR = 1'b0,  // explicit waddr
    SRC_PTR  = 1'b1   // burst pointer
  } wr_src_e;

  // Destination index for a write, given the current source selection.
  function automatic logic [REG_AW-1:0] pick_dest(
    input wr_src_e           src,
    input logic [REG_AW-1:0] ptr,
    input logic [REG_AW-1:0] addr
  );
    return (src == SRC_PTR) ? ptr : addr;
  endfunction

  // Burst pointer advance; relies on natural 3-bit wrap (7 -> 0).
  function automatic logic [REG_AW-1:0] ptr_inc(input logic [REG_AW-1:0] ptr);
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/dmx8_32bits_regs_dec.sv
// Purpose: 3-bit select plus enable to 8-bit one-hot write-enable decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; all-zero output when enable is low.
module dec3to8_en
  import dmx8_32bits_regs_pkg::*;
(
  input  logic [REG_AW-1:0] sel,
  input  logic              en,
  output logic [NREG-1:0]   onehot
);

  // Exactly one bit set when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/dmx8_32bits_regs.sv
// Purpose: 1-to-8 write demux into eight holding registers with valid tracking and burst pointer.
// Latency: written word and its valid flag appear one cycle after the sampling edge.
// Backpressure: none; every write is accepted, including when full (overwrite), clr discards writes.
module dmx8_32bits_regs
  import dmx8_32bits_regs_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              auto,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  q2,
  output logic [WIDTH-1:0]  q3,
  output logic [WIDTH-1:0]  q4,
  output logic [WIDTH-1:0]  q5,
  output logic [WIDTH-1:0]  q6,
  output logic [WIDTH-1:0]  q7,
  output logic [NREG-1:0]   valid,
  output logic [REG_AW-1:0] wptr,
  output logic              full
);

  wr_src_e           src;
  logic [REG_AW-1:0] dest;
  logic              wr_en;
  logic [NREG-1:0]   wr_onehot;
  logic [NREG-1:0]   valid_nxt;
  logic [WIDTH-1:0]  regs [NREG];

  // clr wins over we: a colliding write neither stores data nor moves the pointer.
  assign src   = auto ? SRC_PTR : SRC_ADDR;
  assign dest  = pick_dest(src, wptr, waddr);
  assign wr_en = we & ~clr;

  dec3to8_en u_dec (
    .sel    (dest),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // Valid flags accumulate per written register; rewrites leave them set.
  assign valid_nxt = clr ? '0 : (valid | wr_onehot);

  // Holding registers: only the decoded destination loads, clr leaves data intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_onehot[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Valid flags and full flag; full is a flop so it carries no combinational path to the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      full  <= 1'b0;
    end else begin
      valid <= valid_nxt;
      full  <= &valid_nxt;
    end
  end

  // Burst pointer: advances only on accepted auto-mode writes, cleared by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
    end else if (clr) begin
      wptr <= '0;
    end else if (wr_en && (src == SRC_PTR)) begin
      wptr <= ptr_inc(wptr);
    end
  end

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule

// File: tb/tb_dmx8_32bits_regs.sv
module tb_dmx8_32bits_regs;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic        auto;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        clr;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]  valid;
  logic [2:0]  wptr;
  logic        full;

  int vectors;
  int miscompares;

  logic [31:0] qa [8];

  dmx8_32bits_regs #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .auto    (auto),
    .waddr   (waddr),
    .wdata   (wdata),
    .clr     (clr),
    .q0      (q0),
    .q1      (q1),
    .q2      (q2),
    .q3      (q3),
    .q4      (q4),
    .q5      (q5),
    .q6      (q6),
    .q7      (q7),
    .valid   (valid),
    .wptr    (wptr),
    .full    (full)
  );

  assign qa[0] = q0;
  assign qa[1] = q1;
  assign qa[2] = q2;
  assign qa[3] = q3;
  assign qa[4] = q4;
  assign qa[5] = q5;
  assign qa[6] = q6;
  assign qa[7] = q7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side model of the downstream 32-bit 8:1 read mux.
  function automatic logic [31:0] mux8(input logic [2:0] s);
    return qa[s];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [2:0] addr, input logic [31:0] d);
    we = 1'b1; auto = a; waddr = addr; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0; we = 1'b0; auto = 1'b0; waddr = 3'd0; wdata = 32'h0; clr = 1'b0;
    #2;
    check("rst_q0", q0, 32'h0);
    check("rst_q7", q7, 32'h0);
    check("rst_valid", {24'h0, valid}, 32'h0);
    check("rst_wptr", {29'h0, wptr}, 32'h0);
    check("rst_full", {31'h0, full}, 32'h0);

    // Writes attempted under reset must not land.
    we = 1'b1; wdata = 32'h1234_5678; waddr = 3'd2;
    tick();
    tick();
    check("rst_hold_q2", q2, 32'h0);
    check("rst_hold_valid", {24'h0, valid}, 32'h0);
    we = 1'b0;
    reset_n = 1'b1;
    tick();

    // Addressed write to register 5.
    wr(1'b0, 3'd5, 32'hDEAD_BEEF);
    check("addr_q5", q5, 32'hDEAD_BEEF);
    check("addr_valid", {24'h0, valid}, 32'h0000_0020);
    check("addr_wptr", {29'h0, wptr}, 32'h0);
    check("addr_q4", q4, 32'h0);
    check("addr_q6", q6, 32'h0);

    // Idle cycle: no change.
    tick();
    check("idle_q5", q5, 32'hDEAD_BEEF);
    check("idle_valid", {24'h0, valid}, 32'h0000_0020);

    // Auto burst 0..6; full must still be low (register 7 untouched).
    for (int i = 0; i < 7; i++) wr(1'b1, 3'd7, 32'(i));
    check("burst7_valid", {24'h0, valid}, 32'h0000_007F);
    check("burst7_full", {31'h0, full}, 32'h0);
    check("burst7_wptr", {29'h0, wptr}, 32'h7);
    wr(1'b1, 3'd0, 32'h7);
    check("burst8_valid", {24'h0, valid}, 32'h0000_00FF);
    check("burst8_full", {31'h0, full}, 32'h1);
    check("burst8_wptr", {29'h0, wptr}, 32'h0);
    check("burst8_q0", q0, 32'h0);
    check("burst8_q3", q3, 32'h3);
    check("burst8_q5", q5, 32'h5);
    check("burst8_q7", q7, 32'h7);

    // Ninth write wraps and overwrites q0.
    wr(1'b1, 3'd4, 32'hAA);
    check("wrap_q0", q0, 32'hAA);
    check("wrap_wptr", {29'h0, wptr}, 32'h1);
    check("wrap_full", {31'h0, full}, 32'h1);
    check("wrap_q4", q4, 32'h4);

    // Bring wptr to 3, then clr collides with a write.
    wr(1'b1, 3'd0, 32'hB1);
    wr(1'b1, 3'd0, 32'hB2);
    check("pre_clr_wptr", {29'h0, wptr}, 32'h3);
    clr = 1'b1; we = 1'b1; auto = 1'b1; wdata = 32'h55;
    tick();
    clr = 1'b0; we = 1'b0;
    check("clr_valid", {24'h0, valid}, 32'h0);
    check("clr_wptr", {29'h0, wptr}, 32'h0);
    check("clr_full", {31'h0, full}, 32'h0);
    check("clr_q3", q3, 32'h3);
    check("clr_q1", q1, 32'hB1);

    // Asynchronous reset mid-run, observed between edges.
    wr(1'b1, 3'd0, 32'h99);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_q0", q0, 32'h0);
    check("arst_q3", q3, 32'h0);
    check("arst_valid", {24'h0, valid}, 32'h0);
    check("arst_wptr", {29'h0, wptr}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Mode switch mid-burst keeps the pointer.
    wr(1'b1, 3'd5, 32'h11);
    check("mode_wptr1", {29'h0, wptr}, 32'h1);
    wr(1'b0, 3'd6, 32'h22);
    check("mode_q0", q0, 32'h11);
    check("mode_q6", q6, 32'h22);
    check("mode_wptr_hold", {29'h0, wptr}, 32'h1);
    check("mode_valid", {24'h0, valid}, 32'h0000_0041);

    // Fill all eight from wptr=1 with index-tagged words, then sweep the read mux.
    for (int k = 0; k < 8; k++) wr(1'b1, 3'd0, 32'hCAFE_0000 | 32'((k + 1) % 8));
    check("sweep_full", {31'h0, full}, 32'h1);
    check("sweep_wptr", {29'h0, wptr}, 32'h1);
    for (int s = 0; s < 8; s++) check($sformatf("mux_s%0d", s), mux8(3'(s)), 32'hCAFE_0000 | 32'(s));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
